// File: rtl/seq_multi_pkg.sv
// Shared constants for the radix-2 sequential multiplier.
package seq_multi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter wide enough to hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder chained from FullAdder cells.
module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    FullAdder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/seq_multi.sv
// Sequential shift-add multiplier: one partial product per clock, sign handled by magnitudes.
module seq_multi
  import seq_multi_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   step_sum;
  logic               step_cout;
  logic [2*WIDTH-1:0] prod_final;
  logic [2*WIDTH-1:0] prod_neg;
  logic               neg_cout;

  assign addend = mag_b_q[0] ? mag_a_q : '0;

  ripple_adder #(.WIDTH(WIDTH)) u_acc_add (
    .a   (acc_q),
    .b   (addend),
    .cin (1'b0),
    .sum (step_sum),
    .cout(step_cout)
  );

  assign prod_final = {step_cout, step_sum, mag_b_q[WIDTH-1:1]};

  ripple_adder #(.WIDTH(2 * WIDTH)) u_neg_add (
    .a   (~prod_final),
    .b   ('0),
    .cin (1'b1),
    .sum (prod_neg),
    .cout(neg_cout)
  );

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mag_a_d = (signed_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
          mag_b_d = (signed_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;
          neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        {acc_d, mag_b_d} = prod_final;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          // Negation carry-out flags a zero product, whose negation is itself.
          p_d = (neg_q && !neg_cout) ? prod_neg : prod_final;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);
  assign P    = p_q;

endmodule

// File: tb/tb_seq_multi.sv
// Bench for seq_multi: a WIDTH=3 and a WIDTH=8 instance checked against an arithmetic model.
module tb_seq_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in [2];
  logic       st     [2];
  logic       sm     [2];
  logic [7:0] a_in   [2];
  logic [7:0] b_in   [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [5:0] p3;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  seq_multi #(.WIDTH(3)) dut3 (
    .clk        (clk),
    .rst        (rst_in[0]),
    .start      (st[0]),
    .signed_mode(sm[0]),
    .A          (a_in[0][2:0]),
    .B          (b_in[0][2:0]),
    .busy       (busy_o[0]),
    .done       (done_o[0]),
    .P          (p3)
  );

  seq_multi #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst_in[1]),
    .start      (st[1]),
    .signed_mode(sm[1]),
    .A          (a_in[1]),
    .B          (b_in[1]),
    .busy       (busy_o[1]),
    .done       (done_o[1]),
    .P          (p8)
  );

  function automatic int wof(input int i);
    return (i == 0) ? 3 : 8;
  endfunction

  function automatic logic [15:0] pget(input int i);
    return (i == 0) ? {10'b0, p3} : p8;
  endfunction

  // Product of the operands interpreted as w-bit values, reduced mod 2^(2w).
  function automatic logic [15:0] model_prod(input int w, input logic s,
                                             input logic [7:0] a, input logic [7:0] b);
    longint av, bv, pr, lim;
    lim = longint'(1) << w;
    av  = longint'(a) & (lim - 1);
    bv  = longint'(b) & (lim - 1);
    if (s && av >= lim / 2) av = av - lim;
    if (s && bv >= lim / 2) bv = bv - lim;
    pr = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return 16'(pr);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle model: an accepted start occupies WIDTH cycles, then one done cycle.
  int          rem      [2];
  logic [15:0] pend     [2];
  logic [15:0] exp_p    [2];
  logic        exp_done [2];
  bit          armed = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_in[i]) begin
        rem[i] = 0;
        exp_done[i] = 1'b0;
        exp_p[i] = '0;
      end else if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        exp_done[i] = (rem[i] == 0);
        if (rem[i] == 0) exp_p[i] = pend[i];
      end else begin
        exp_done[i] = 1'b0;
        if (st[i]) begin
          rem[i]  = wof(i);
          pend[i] = model_prod(wof(i), sm[i], a_in[i], b_in[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i), 16'(busy_o[i]), 16'(rem[i] > 0));
        chk($sformatf("done[%0d]", i), 16'(done_o[i]), 16'(exp_done[i]));
        chk($sformatf("P[%0d]", i), pget(i), exp_p[i]);
        chk($sformatf("busy_and_done[%0d]", i), 16'(busy_o[i] & done_o[i]), 16'd0);
      end
    end
  end

  task automatic run_op(input int i, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] lit, input string name);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    st[i] = 1'b1;
    sm[i] = s;
    a_in[i] = a;
    b_in[i] = b;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      st[i] = 1'b0;
      if (done_o[i]) got = 1'b1;
    end
    chk({name, "_latency"}, 16'(n), 16'(wof(i) + 1));
    chk({name, "_P"}, pget(i), lit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, seen, t1;
    for (int i = 0; i < 2; i++) begin
      rst_in[i] = 1'b1;
      st[i] = 1'b0;
      sm[i] = 1'b0;
      a_in[i] = '0;
      b_in[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_in[0] = 1'b0;
    rst_in[1] = 1'b0;
    armed = 1'b1;
    chk("reset_busy", 16'(busy_o[1]), 16'd0);
    chk("reset_done", 16'(done_o[1]), 16'd0);
    chk("reset_P8", p8, 16'd0);
    chk("reset_P3", {10'b0, p3}, 16'd0);

    // Exhaustive unsigned 3x3.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        run_op(0, 1'b0, 8'(a), 8'(b), 16'(a * b), $sformatf("u3_%0dx%0d", a, b));

    run_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, "s8_m128sq");
    run_op(1, 1'b1, 8'hFF, 8'h01, 16'hFFFF, "s8_m1x1");
    run_op(1, 1'b1, 8'h7F, 8'h81, 16'hC0FF, "s8_127xm127");
    run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u8_ffxff");
    run_op(1, 1'b0, 8'h00, 8'hAB, 16'h0000, "u8_zero");

    // Start held high: back-to-back results, CALC-time input changes ignored.
    @(negedge clk);
    st[1] = 1'b1;
    sm[1] = 1'b0;
    a_in[1] = 8'd5;
    b_in[1] = 8'd6;
    n = 0;
    seen = 0;
    t1 = 0;
    while (n < 40 && seen < 2) begin
      @(negedge clk);
      n++;
      if (done_o[1]) begin
        seen++;
        if (seen == 1) begin
          chk("b2b_P1", p8, 16'd30);
          t1 = n;
          sm[1] = 1'b0;
          a_in[1] = 8'd3;
          b_in[1] = 8'd4;
        end else begin
          chk("b2b_P2", p8, 16'd12);
          chk("b2b_gap", 16'(n - t1), 16'd9);
          st[1] = 1'b0;
        end
      end else if (busy_o[1]) begin
        a_in[1] = 8'($urandom);
        b_in[1] = 8'($urandom);
        sm[1] = 1'($urandom);
      end
    end
    chk("b2b_done_count", 16'(seen), 16'd2);
    st[1] = 1'b0;
    @(negedge clk);

    // Reset on the 4th CALC cycle aborts without a done.
    @(negedge clk);
    st[1] = 1'b1;
    a_in[1] = 8'd200;
    b_in[1] = 8'd100;
    repeat (4) begin
      @(negedge clk);
      st[1] = 1'b0;
    end
    rst_in[1] = 1'b1;
    @(negedge clk);
    rst_in[1] = 1'b0;
    chk("abort_busy", 16'(busy_o[1]), 16'd0);
    chk("abort_done", 16'(done_o[1]), 16'd0);
    chk("abort_P", p8, 16'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[1]) seen++;
    end
    chk("abort_no_done", 16'(seen), 16'd0);
    run_op(1, 1'b0, 8'd2, 8'd3, 16'd6, "after_abort");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multi.md
Name: seq_multi

Overview:
- Parametrised sequential multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
- Radix-2 shift-add datapath, one partial product per clock, with a start/done handshake.
- Selectable unsigned or two's-complement signed operation per transaction.
- Next generation of the lab's combinational 3x3 array multiplier. It is the arithmetic unit for later datapath labs where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when not busy
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle pulse: P is valid
- P  output  2*WIDTH  product register; holds value until the next result

Behaviour:
- Reset: one clock; reset is synchronous and active-high. At any clk edge with rst=1: state=IDLE, busy=0, done=0, P=0, all internal registers=0. Reset has priority over start and aborts an in-flight multiplication; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1 at edge k:
  - latch mag_a=|A| and mag_b=|B| (absolute value only when signed_mode=1; otherwise raw), and neg = signed_mode & (A[MSB]^B[MSB]);
  - acc=0, cnt=0; go to CALC.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits WIDTH unsigned bits; no overflow.
- CALC: each edge:
  - if mag_b[0], add mag_a to upper WIDTH bits of acc with carry out;
  - shift {carry, acc, mag_b} right by one; cnt++.
  - After the WIDTH-th CALC edge (edge k+WIDTH), go to DONE.
  - On that same edge, write P = neg ? -acc_final : acc_final, computed modulo 2^(2*WIDTH).
- DONE lasts exactly one cycle with done=1, busy=0. Then go to IDLE if start=0; with start=1, a new operation begins (back-to-back, no bubble).
- Timing:
  - busy=1 in every CALC cycle, i.e. the WIDTH cycles following edge k.
  - done=1 in the cycle after edge k+WIDTH.
  - Latency: start edge to done = WIDTH+1 edges.
- start while busy=1 is ignored; A, B and signed_mode may change freely during CALC.
- P changes only on the DONE-entry edge and on reset. It is stable from done until the next done.
- signed_mode=0 with MSB set: treated as a large unsigned value; neg=0.
- Zero operands follow the normal path; latency is fixed and there is no early termination.
- done and busy are never high together.

Decomposition:
- Package seq_multi_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - counter width localparam CNT_W = clog2(WIDTH+1).
- Sub-module ripple_adder #(WIDTH): a WIDTH-bit ripple-carry adder built from the existing FullAdder cell. Inputs a, b, cin; outputs sum, cout.
  - Used for the accumulate step.
  - A second instance with an inverted operand and cin=1 performs the final two's-complement negation.
  - The FSM, counter and shift registers stay in seq_multi.

Test Plan:
- WIDTH=3, signed_mode=0, exhaustive A,B in 0..7 -> P = A*B for all 64 pairs (e.g. 7*7 -> 6'd49); done exactly 4 edges after start each time.
- WIDTH=8, signed_mode=1:
  - A=8'h80 (-128), B=8'h80 -> P=16'h4000;
  - A=8'hFF (-1), B=8'h01 -> P=16'hFFFF;
  - A=8'h7F, B=8'h81 (-127) -> P=16'hC0FF (-16129).
- WIDTH=8, signed_mode=0: A=8'hFF, B=8'hFF -> P=16'hFE01; A=0, B=8'hAB -> P=0 with full 9-edge latency.
- Start held high continuously, WIDTH=8:
  - operands A=5, B=6, then A=3, B=4 applied at the DONE cycle;
  - P=30 and then P=12, done pulses exactly 9 edges apart;
  - operand changes and start pulses during CALC have no effect.
- Reset mid-operation: start A=200, B=100, assert rst on the 4th CALC cycle -> next cycle busy=0, done=0, P=0, no done follows; a fresh start with A=2, B=3 then yields P=6.
- Check on every cycle: done and busy are never both 1, and P changes only on the DONE-entry edge or on reset.
